// File: rtl/shift_seq_ctrl_pkg.sv
// Shared constants and types for the sequenced shift unit.
package shift_seq_ctrl_pkg;

  localparam int unsigned SSC_WIDTH = 32;
  localparam int unsigned SSC_AMT_W = 5;
  localparam int unsigned SSC_K_W   = 3;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage_var.sv
// One conditional shift stage: shifts by 2^j where sel is one-hot in j,
// left (dir=0) or right (dir=1), filling vacated bits with `fill`.
module shift_stage_var #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSEL  = 5
) (
  input  logic [WIDTH-1:0] din,
  input  logic [NSEL-1:0]  sel,
  input  logic             dir,
  input  logic             fill,
  input  logic             en,
  output logic [WIDTH-1:0] shifted_c
);

  // Per bit: a chain of 2:1 muxes, one per candidate amount; one-hot select
  // means at most one link replaces the unshifted bit.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    logic [NSEL:0] chain;
    assign chain[0] = din[i];

    for (genvar j = 0; j < int'(NSEL); j++) begin : g_amt
      localparam int S = 1 << j;
      logic from_left;
      logic from_right;
      logic cand;

      if (i >= S) begin : g_l
        assign from_left = din[i - S];
      end else begin : g_lf
        assign from_left = fill;
      end

      if (i + S < int'(WIDTH)) begin : g_r
        assign from_right = din[i + S];
      end else begin : g_rf
        assign from_right = fill;
      end

      assign cand         = dir ? from_right : from_left;
      assign chain[j + 1] = (en & sel[j]) ? cand : chain[j];
    end

    assign shifted_c[i] = chain[NSEL];
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift controller: walks one shared shift stage through the
// 16/8/4/2/1 amounts, then presents the result for one DONE cycle.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = SSC_WIDTH,
  parameter int unsigned AMT_W = SSC_AMT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [1:0]       ctrl_op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             result_ready,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned K_W = SSC_K_W;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [1:0]       op_q, op_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0] result_d;
  logic             busy_d;
  logic             ready_d;

  logic [AMT_W-1:0] sel;
  logic             stage_en;
  logic             dir;
  logic             fill;
  logic [WIDTH-1:0] stage_out;

  // Stage k applies amount 2^(AMT_W-1-k) when that bit of the latched amount is set.
  always_comb begin
    sel = '0;
    for (int unsigned j = 0; j < AMT_W; j++) begin
      sel[j] = (k_q == K_W'(AMT_W - 1 - j));
    end
    stage_en = |(sel & amt_q);
  end

  // Direction and fill per op; the working MSB stays equal to the original sign under SRA.
  always_comb begin
    dir  = 1'b0;
    fill = 1'b0;
    case (op_q)
      OP_SLL: begin dir = 1'b0; fill = 1'b0; end
      OP_SRL: begin dir = 1'b1; fill = 1'b0; end
      OP_SRA: begin dir = 1'b1; fill = work_q[WIDTH-1]; end
      default: begin dir = 1'b0; fill = 1'b0; end
    endcase
  end

  shift_stage_var #(
    .WIDTH (WIDTH),
    .NSEL  (AMT_W)
  ) u_stage (
    .din       (work_q),
    .sel       (sel),
    .dir       (dir),
    .fill      (fill),
    .en        (stage_en),
    .shifted_c (stage_out)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    amt_d    = amt_q;
    op_d     = op_q;
    k_d      = k_q;
    result_d = result;
    busy_d   = 1'b0;
    ready_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (ctrl_start) begin
          work_d  = data_in;
          amt_d   = amt;
          op_d    = ctrl_op;
          k_d     = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = stage_out;
        k_d    = k_q + K_W'(1);
        if (k_q == K_W'(AMT_W - 1)) begin
          result_d = stage_out;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      work_q       <= '0;
      amt_q        <= '0;
      op_q         <= '0;
      k_q          <= '0;
      result       <= '0;
      busy         <= 1'b0;
      result_ready <= 1'b0;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      amt_q        <= amt_d;
      op_q         <= op_d;
      k_q          <= k_d;
      result       <= result_d;
      busy         <= busy_d;
      result_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: cycle-accurate behavioural model
// (countdown + shift operators) compared every cycle, plus directed literals.
module tb_shift_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_start;
  logic [1:0]  ctrl_op;
  logic [31:0] data_in;
  logic [4:0]  amt;
  logic        busy;
  logic        result_ready;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_seen = 0;

  // Model: remaining cycles of the current operation (6 after accept, 1 = DONE).
  int          m_cnt = 0;
  int          m_acc = 0;
  int          m_done = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_result = '0;
  bit          chk_on = 1'b0;

  shift_seq_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .ctrl_start   (ctrl_start),
    .ctrl_op      (ctrl_op),
    .data_in      (data_in),
    .amt          (amt),
    .busy         (busy),
    .result_ready (result_ready),
    .result       (result)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] a);
    case (op)
      2'b01:   return d >> a;
      2'b11:   return 32'($signed(d) >>> a);
      default: return d << a;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, got, want, $time);
    end
  endtask

  // Behavioural model advances on each rising edge.
  always @(posedge clock) begin
    if (reset) begin
      m_cnt    = 0;
      m_result = '0;
    end else begin
      if (m_cnt <= 1 && ctrl_start) begin
        m_pend = ref_shift(ctrl_op, data_in, amt);
        m_cnt  = 6;
        m_acc++;
      end else if (m_cnt > 0) begin
        m_cnt--;
      end
      if (m_cnt == 1) begin
        m_result = m_pend;
        m_done++;
      end
    end
  end

  // Compare DUT outputs to the model mid-cycle.
  always @(negedge clock) begin
    if (chk_on) begin
      check("busy", 32'(busy), 32'(m_cnt != 0));
      check("result_ready", 32'(result_ready), 32'(m_cnt == 1));
      check("result", result, m_result);
      if (result_ready) rdy_seen++;
    end
  end

  task automatic wait_ready(inout int lat);
    while (!result_ready && lat < 12) begin
      @(negedge clock);
      lat++;
    end
  endtask

  // Issue a start at the current negedge and check result and 6-cycle latency.
  task automatic do_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] a,
                       input logic [31:0] want, input string nm);
    int lat;
    ctrl_start = 1'b1;
    ctrl_op    = op;
    data_in    = d;
    amt        = a;
    @(negedge clock);
    ctrl_start = 1'b0;
    data_in    = $urandom;
    amt        = 5'($urandom);
    ctrl_op    = 2'($urandom);
    lat = 1;
    wait_ready(lat);
    check({nm, "_lat"}, 32'(lat), 32'd6);
    check(nm, result, want);
    check({nm, "_model"}, ref_shift(op, d, a), want);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc0;
    int rdy0;

    reset      = 1'b1;
    ctrl_start = 1'b1;
    ctrl_op    = 2'b00;
    data_in    = 32'h1234_5678;
    amt        = 5'd3;
    @(posedge clock);
    chk_on = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'h0000_0000);
    check("rst_ready", 32'(result_ready), 32'd0);
    reset      = 1'b0;
    ctrl_start = 1'b0;
    @(negedge clock);
    check("idle_busy", 32'(busy), 32'd0);

    do_op(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll31");
    @(negedge clock);
    do_op(2'b11, 32'h8000_0F00, 5'd8, 32'hFF80_000F, "sra8");
    @(negedge clock);
    do_op(2'b01, 32'h8000_0F00, 5'd8, 32'h0080_000F, "srl8");
    @(negedge clock);
    do_op(2'b11, 32'h8000_0F00, 5'd0, 32'h8000_0F00, "sra0");
    @(negedge clock);
    do_op(2'b10, 32'h0000_0001, 5'd4, 32'h0000_0010, "rsvd4");

    // Start ignored during SHIFT, then a back-to-back start in DONE.
    @(negedge clock);
    ctrl_start = 1'b1; ctrl_op = 2'b00; data_in = 32'h0000_ABCD; amt = 5'd4;
    @(negedge clock);
    ctrl_start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    ctrl_start = 1'b1; ctrl_op = 2'b11; data_in = 32'hFFFF_0000; amt = 5'd3;
    @(negedge clock);
    ctrl_start = 1'b0;
    lat = 4;
    wait_ready(lat);
    check("ign_lat", 32'(lat), 32'd6);
    check("ign_result", result, 32'h000A_BCD0);
    do_op(2'b01, 32'hF000_0000, 5'd28, 32'h0000_000F, "b2b_srl28");

    // Reset on the third SHIFT cycle aborts the operation.
    @(negedge clock);
    ctrl_start = 1'b1; ctrl_op = 2'b11; data_in = 32'hFFFF_FFFF; amt = 5'd5;
    @(negedge clock);
    ctrl_start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'h0000_0000);
    check("abort_ready", 32'(result_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    do_op(2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C, "post_rst");

    // Random regression: random starts every cycle, many land in SHIFT or DONE.
    @(negedge clock);
    acc0 = m_acc;
    rdy0 = rdy_seen;
    for (int c = 0; c < 15000 && (m_acc - acc0) < 1000; c++) begin
      ctrl_start = ($urandom_range(0, 1) == 1);
      ctrl_op    = 2'($urandom);
      data_in    = $urandom;
      amt        = 5'($urandom);
      @(negedge clock);
    end
    ctrl_start = 1'b0;
    repeat (8) @(negedge clock);
    check("rand_accepted", 32'(m_acc - acc0), 32'd1000);
    check("rand_ready_count", 32'(rdy_seen - rdy0), 32'(m_acc - acc0));
    check("total_ready_count", 32'(rdy_seen), 32'(m_done));
    check("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle shift unit controller for the processor execute stage.
- Sequences one shared conditional-shift stage through the 16/8/4/2/1 amounts over five cycles, instead of five parallel stages, to save LEs.
- Supports logical left, logical right and arithmetic right shifts.
- Handshakes with the pipeline stall logic through `busy` and `result_ready`, the same way as the multiply/divide unit.

Parameters:
- WIDTH, 32, datapath width; fixed at 32 for this processor.
- AMT_W, 5, shift-amount width; equals log2(WIDTH) and equals the number of SHIFT cycles.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ctrl_start  in  1  request pulse; operands are sampled when it is accepted.
- ctrl_op  in  2  00 = SLL, 01 = SRL, 11 = SRA, 10 = reserved (treated as SLL).
- data_in  in  WIDTH  operand to shift.
- amt  in  AMT_W  shift amount 0..31.
- busy  out  1  high while an accepted operation is in progress.
- result_ready  out  1  one-cycle pulse when `result` is valid.
- result  out  WIDTH  shifted value; held until the next accepted start.

Behaviour:
- Reset values: state = IDLE, `busy` = 0, `result_ready` = 0, `result` = 0, internal operand/amount/op/stage registers = 0.
- States: IDLE, SHIFT, DONE.
  - IDLE: start accepted if `ctrl_start` = 1. Latch `data_in` into the working register, plus `amt` and `ctrl_op`. Stage counter k = 0. Go to SHIFT.
  - SHIFT: each cycle, if latched amt[4-k] = 1, working register = working register shifted by 2^(4-k) per op; otherwise unchanged. Shift amounts are 16, 8, 4, 2, 1 for k = 0..4. k increments each cycle. After k = 4, go to DONE.
  - DONE: `result` = working register and `result_ready` = 1 for exactly this cycle. Next state is IDLE, or SHIFT if `ctrl_start` = 1 (back-to-back accept).
- Fill rules:
  - SLL zero-fills the LSBs.
  - SRL zero-fills the MSBs.
  - SRA replicates the latched operand's bit 31 (the sign is taken from the original operand, which is unchanged by any right-shift stage).
- Latency:
  - Start sampled at edge E0.
  - SHIFT occupies the cycles after edges E0..E4.
  - DONE (`result_ready` high) is the cycle after E5.
  - The result is therefore available 6 cycles after the start is sampled, independent of `amt` (`amt` = 0 still takes 6 cycles).
- `busy` = 1 in SHIFT and DONE, 0 in IDLE. Stall logic must not issue a new start except in IDLE or DONE.
- A `ctrl_start` while in SHIFT is ignored: no latch and no error. Operand inputs changing during SHIFT have no effect.
- Throughput: one result every 6 cycles with back-to-back starts issued in DONE.
- `result` changes only on entry to DONE (loaded from the working register) and is otherwise stable. The working register is not visible on `result` during SHIFT.
- Reset mid-operation: on the next edge, state = IDLE, `result` = 0, no `result_ready` pulse. The aborted operation is lost.
- Reset and `ctrl_start` asserted in the same cycle: reset wins and the start is not accepted.
- Arithmetic is pure bit movement: no overflow or flags. Shifting by 31 is legal; there is no wrap-around of `amt`.

Decomposition:
- Shared package / include file:
  - Op-code constants: OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b11.
  - State encodings: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - WIDTH and AMT_W defaults.
- One sub-module, `shift_stage_var`: a combinational conditional shift of a WIDTH-bit value by 2^k (k selected by a 3-bit or one-hot select), with direction and fill-bit inputs and an enable.
  - Built structurally, using the existing 2-to-1 mux cells per bit.
  - The controller instantiates it once and feeds it from the working register.

Test Plan:
- Reset then idle: hold `reset` 2 cycles with `ctrl_start` = 1 → `busy` = 0, `result` = 0x00000000, `result_ready` never asserts.
- SLL: `data_in` = 0x00000001, `amt` = 31, op = SLL, start at E0 → `result_ready` pulses once in the cycle after E5, `result` = 0x80000000, `busy` high for exactly 6 cycles.
- SRA vs SRL: `data_in` = 0x80000F00, `amt` = 8.
  - SRA → 0xFF80000F.
  - Repeat with SRL → 0x0080000F.
  - `amt` = 0 with SRA → 0x80000F00, still 6-cycle latency.
- Back-to-back and ignored start: start SLL (0x0000ABCD, `amt` = 4) → result 0x000ABCD0. `ctrl_start` is pulsed during SHIFT with other operands and must be ignored. A start issued in the DONE cycle (SRL, 0xF0000000, `amt` = 28) must return 0x0000000F exactly 6 cycles later.
- Reset mid-operation: start SRA (0xFFFFFFFF, `amt` = 5), assert `reset` on the 3rd SHIFT cycle → next cycle `busy` = 0, `result` = 0, no `result_ready`. A fresh start afterwards completes normally.
- Random regression: 1000 random op/`data_in`/`amt` triples compared against a behavioural <<, >>, >>> model; `result_ready` count equals the accepted start count.
